// File: rtl/data_mem_dumper.sv
// Post-halt dump of a window of DATA_MEM onto a byte stream (MS byte first) with a
// valid/ready handshake, for a UART TX to carry to the host. Read-only: never writes memory.
module data_mem_dumper #(
    parameter int len_addr   = 11,
    parameter int len_data   = 16,
    parameter int ram_depth  = 2048,
    parameter int base_addr  = 0,
    parameter int dump_words = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                Mem_Rd,
    output logic [len_addr-1:0] Mem_Addr,
    input  logic [len_data-1:0] Mem_Out_Data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done
);

    localparam int NBYTES = len_data / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WCW    = (dump_words > 1) ? $clog2(dump_words) : 1;

    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [WCW-1:0]      LAST_WORD = WCW'(dump_words - 1);
    localparam logic [len_addr-1:0] BASE      = len_addr'(base_addr);
    localparam logic [len_addr-1:0] TOP       = len_addr'(ram_depth - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [len_addr-1:0]   addr_q, addr_d;
    logic                  rd_q, rd_d;
    logic [7:0]            txd_q, txd_d;
    logic                  txv_q, txv_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic [len_data-1:0]   shift_q, shift_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        txd_d   = txd_q;
        txv_d   = txv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        shift_d = shift_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = BASE;
                    wcnt_d  = '0;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Remaining bytes queue up behind the MS byte already on tx_data.
                shift_d = Mem_Out_Data << 8;
                txd_d   = Mem_Out_Data[len_data-1 -: 8];
                txv_d   = 1'b1;
                bcnt_d  = LAST_BYTE;
                state_d = SEND;
            end
            SEND: begin
                if (txv_q && tx_ready) begin
                    if (bcnt_q != '0) begin
                        txd_d   = shift_q[len_data-1 -: 8];
                        shift_d = shift_q << 8;
                        bcnt_d  = bcnt_q - 1'b1;
                    end else begin
                        txv_d = 1'b0;
                        if (wcnt_q != LAST_WORD) begin
                            wcnt_d  = wcnt_q + 1'b1;
                            addr_d  = (addr_q == TOP) ? '0 : addr_q + 1'b1;
                            rd_d    = 1'b1;
                            state_d = READ;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            rd_q    <= 1'b0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Pure data holding register; every use is preceded by a CAPTURE load.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign Mem_Rd   = rd_q;
    assign Mem_Addr = addr_q;
    assign tx_data  = txd_q;
    assign tx_valid = txv_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_data_mem_dumper.sv
// Randomized scoreboard bench for data_mem_dumper: a behavioural memory plus a queue of
// expected bytes/addresses per dump, checked by an independent monitor.
module tb_data_mem_dumper;

    localparam int BASE  = 2045;
    localparam int WORDS = 5;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        Mem_Rd;
    logic [10:0] Mem_Addr;
    logic [15:0] Mem_Out_Data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    data_mem_dumper #(
        .len_addr(11), .len_data(16), .ram_depth(DEPTH),
        .base_addr(BASE), .dump_words(WORDS)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .Mem_Rd(Mem_Rd), .Mem_Addr(Mem_Addr), .Mem_Out_Data(Mem_Out_Data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the read strobe.
    logic [15:0] mem [0:DEPTH-1];
    logic [15:0] mem_q;
    always @(posedge clk) if (Mem_Rd) mem_q <= mem[Mem_Addr];
    assign Mem_Out_Data = mem_q;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  byte_q [$];
    logic [10:0] addr_q [$];
    bit          exp_active = 1'b0;
    int          rd_cnt = 0, byte_cnt = 0, done_cnt = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 3) != 0);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: at each falling edge, judge what the next rising edge will do.
    initial begin
        bit         prev_v = 0, prev_x = 0, prev_rd = 0, prev_done = 0;
        logic [7:0] prev_d = '0;
        bit         xfer;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_v = 0; prev_x = 0; prev_rd = 0; prev_done = 0;
            end else begin
                if (Mem_Rd) begin
                    if (prev_rd) fail("mem_rd_width");
                    if (addr_q.size() == 0) fail("mem_rd_extra");
                    else check("mem_addr", Mem_Addr, addr_q.pop_front());
                    rd_cnt++;
                end
                if (prev_v && !prev_x) begin
                    check("hold_valid", tx_valid, 1);
                    check("hold_data", tx_data, prev_d);
                end
                xfer = tx_valid && tx_ready;
                if (xfer) begin
                    if (byte_q.size() == 0) fail("tx_byte_extra");
                    else check("tx_byte", tx_data, byte_q.pop_front());
                    byte_cnt++;
                end
                if (exp_active && !done) check("busy_in_dump", busy, 1);
                if (done) begin
                    done_cnt++;
                    if (prev_done) fail("done_width");
                    if (!exp_active) fail("done_unexpected");
                    check("done_bytes_left", byte_q.size(), 0);
                    check("done_reads_left", addr_q.size(), 0);
                    check("busy_at_done", busy, 0);
                    exp_active = 1'b0;
                end
                prev_v = tx_valid; prev_x = xfer; prev_d = tx_data;
                prev_rd = Mem_Rd; prev_done = done;
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    endtask

    task automatic expect_dump();
        for (int w = 0; w < WORDS; w++) begin
            int a;
            a = (BASE + w) % DEPTH;
            addr_q.push_back(11'(a));
            byte_q.push_back(mem[a][15:8]);
            byte_q.push_back(mem[a][7:0]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"}, Mem_Rd, 0);
        check({tag, "_mem_addr"}, Mem_Addr, BASE);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_dump(input bit timing, input bit junk, input int stall_at, input int reset_at);
        int  rd0, b0, d0, cyc, stall_left, saved;
        bit  stalled, seen_done;
        rd0 = rd_cnt; b0 = byte_cnt; d0 = done_cnt;
        stall_left = 0; stalled = 0; seen_done = 0; saved = rdy_mode;
        expect_dump();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        check("lat_rd_after_start", Mem_Rd, 1);
        check("lat_addr_base", Mem_Addr, BASE);
        check("lat_busy", busy, 1);
        check("lat_valid_early0", tx_valid, 0);
        exp_active = 1'b1;
        start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        check("lat_valid_early1", tx_valid, 0);
        check("lat_rd_one_cycle", Mem_Rd, 0);
        @(posedge clk); #1;
        check("lat_valid_n2", tx_valid, 1);
        cyc = 3;
        while (cyc < 2000) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1;
                break;
            end
            start = (junk && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (reset_at >= 0 && (byte_cnt - b0) >= reset_at) begin
                @(posedge clk); #3;
                reset = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                byte_q.delete();
                addr_q.delete();
                exp_active = 1'b0;
                start = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                return;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) rdy_mode = saved;
            end else if (stall_at >= 0 && !stalled && (byte_cnt - b0) >= stall_at) begin
                saved = rdy_mode; rdy_mode = 2; stall_left = 5; stalled = 1;
            end
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        rdy_mode = saved;
        if (!seen_done) fail("dump_timeout");
        if (timing) check("dump_cycles", cyc, 4 * WORDS + 2);
        check("dump_mem_rd_count", rd_cnt - rd0, WORDS);
        check("dump_byte_count", byte_cnt - b0, 2 * WORDS);
        check("dump_done_count", done_cnt - d0, 1);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        fill_mem();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Known word at base: 0x12 then 0x34 with no gaps.
        mem[BASE] = 16'h1234;
        rdy_mode = 0;
        run_dump(1'b1, 1'b0, -1, -1);

        // Stall mid-word after the MS byte goes out.
        fill_mem();
        run_dump(1'b0, 1'b0, 1, -1);

        // Random backpressure and repeated start pulses during the dump.
        fill_mem();
        rdy_mode = 1;
        run_dump(1'b0, 1'b1, -1, -1);

        // Asynchronous reset while word 3 is being sent, then a fresh dump from base.
        fill_mem();
        run_dump(1'b0, 1'b0, -1, 6);
        fill_mem();
        rdy_mode = 0;
        run_dump(1'b1, 1'b1, -1, -1);

        for (int k = 0; k < 3; k++) begin
            fill_mem();
            rdy_mode = 1;
            run_dump(1'b0, 1'b1, (k == 1) ? 3 : -1, -1);
        end

        repeat (3) @(negedge clk);
        check("idle_busy_end", busy, 0);
        check("idle_valid_end", tx_valid, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
